fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
Parameters:
REQ-001 SHALL have parameter WL, default 32: PC, address and immediate width.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
Ports:
REQ-003 SHALL have CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have Branch  input  1  branch request from control_unit.
REQ-006 SHALL have Jump  input  1  jump request from control_unit.
REQ-007 SHALL have Zero  input  1  ALU zero flag.
REQ-008 SHALL have SImm  input  WL  sign-extended immediate, Instr[15:0].
REQ-009 SHALL have Stall  input  1  hold current instruction in EXEC.
REQ-010 SHALL have IMReq  output  1  instruction-memory read request.
REQ-011 SHALL have IMAddr  output  WL  instruction-memory byte address.
REQ-012 SHALL have IMRdata  input  32  instruction-memory read data.
REQ-013 SHALL have IMValid  input  1  IMRdata valid for current request.
REQ-014 SHALL have Instr  output  32  latched instruction.
REQ-015 SHALL have Opcode  output  6  Instr[31:26], to control_unit.
REQ-016 SHALL have funct  output  6  Instr[5:0], to control_unit.
REQ-017 SHALL have InstrValid  output  1  Instr is decodable this cycle.
REQ-018 SHALL have PC  output  WL  address of the current instruction.
REQ-019 SHALL have PCPlus4  output  WL  PC+4.
REQ-020 SHALL have InstrCount  output  32  retired-instruction count.

Function
REQ-021 SHALL implement a three-state FSM: IDLE, FETCH, EXEC.
REQ-022 IDLE SHALL go to FETCH unconditionally after one cycle.
REQ-023 In FETCH: IMReq=1, IMAddr=PC; when IMValid=1, Instr SHALL latch IMRdata and the FSM SHALL go to EXEC; otherwise it SHALL stay in FETCH with IMAddr stable.
REQ-024 IMValid SHALL be ignored outside FETCH; IMReq SHALL be 0 in IDLE and EXEC.
REQ-025 In EXEC: InstrValid=1, and Instr, PC and PCPlus4 SHALL be held stable.
REQ-026 In EXEC with Stall=1, the FSM SHALL stay in EXEC with no PC or InstrCount change.
REQ-027 In EXEC with Stall=0, PC SHALL load NextPC, InstrCount SHALL increment by 1, and the FSM SHALL go to FETCH.
REQ-028 NextPC priority: Jump=1 -> {PCPlus4[WL-1:28], Instr[25:0], 2'b00}; else Branch=1 and Zero=1 -> PCPlus4 + (SImm<<2); else PCPlus4.
REQ-029 Jump SHALL override Branch, including when Branch is X.
REQ-030 All PC arithmetic SHALL be modulo 2^WL: PC=FFFFFFFC gives PCPlus4=00000000.
REQ-031 InstrCount SHALL wrap from FFFFFFFF to 0.
REQ-032 Branch, Jump, Zero and SImm SHALL be sampled only on the EXEC exit edge.
REQ-033 Minimum throughput SHALL be one instruction per 2 cycles, with zero-wait memory (IMValid in the same cycle as IMReq).
REQ-034 Opcode, funct and PCPlus4 SHALL be combinational from Instr and PC.

Reset
REQ-035 While RST=1, regardless of state, the block SHALL force: FSM=IDLE, PC=RESET_PC, IMAddr=RESET_PC, Instr=0, InstrValid=0, IMReq=0, InstrCount=0.
REQ-036 Reset during FETCH SHALL abort the request, and a late IMValid SHALL NOT be latched.
REQ-037 After RST deasserts, IMReq SHALL first assert on the 2nd rising edge.

Verification
REQ-038 Reset, then zero-wait memory returning 00000020 -> IMReq at edge 2 with IMAddr=0; InstrValid in the following cycle, Opcode=0, funct=20; next IMAddr=4.
REQ-039 Branch=1, Zero=1, SImm=FFFFFFFF at PC=8 -> next IMAddr=8; with Zero=0 -> next IMAddr=C.
REQ-040 Jump=1, Branch=X, Instr[25:0]=0000010, PC=00400000 -> next IMAddr=00000040; InstrCount +1.
REQ-041 IMValid delayed 3 cycles -> IMReq held 4 cycles with a stable IMAddr; Instr changes only on the IMValid edge.
REQ-042 Stall=1 for 5 EXEC cycles -> Instr, PC and InstrCount unchanged; advance on the first Stall=0 edge.
REQ-043 RST pulse mid-FETCH, then IMValid=1 -> PC=RESET_PC, Instr=0, InstrCount=0, IMReq=0 until the 2nd edge after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/EXEC sequencer that owns the PC, fetches one
// instruction per visit to FETCH and retires it when EXEC is left without a stall.
module fetch_unit #(
  parameter int unsigned    WL       = 32,
  parameter logic [WL-1:0]  RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Branch,
  input  logic          Jump,
  input  logic          Zero,
  input  logic [WL-1:0] SImm,
  input  logic          Stall,
  output logic          IMReq,
  output logic [WL-1:0] IMAddr,
  input  logic [31:0]   IMRdata,
  input  logic          IMValid,
  output logic [31:0]   Instr,
  output logic [5:0]    Opcode,
  output logic [5:0]    funct,
  output logic          InstrValid,
  output logic [WL-1:0] PC,
  output logic [WL-1:0] PCPlus4,
  output logic [31:0]   InstrCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          armed;
  logic [WL-1:0] next_pc;

  assign PCPlus4    = PC + WL'(4);
  assign Opcode     = Instr[31:26];
  assign funct      = Instr[5:0];
  assign IMReq      = (state == FETCH);
  assign IMAddr     = PC;
  assign InstrValid = (state == EXEC);

  // Jump is tested first so an unknown Branch can never steer a jump.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    next_pc = PCPlus4;
    if (Jump) begin
      next_pc = {PCPlus4[WL-1:28], Instr[25:0], 2'b00};
    end else if (Branch && Zero) begin
      next_pc = PCPlus4 + (SImm << 2);
    end
  end

  // The first edge after reset release only arms the sequencer, so IMReq rises
  // on the second edge and a partial cycle after release never counts as IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (armed)    state_next = FETCH;
      FETCH:   if (IMValid)  state_next = EXEC;
      EXEC:    if (!Stall)   state_next = FETCH;
      default:               state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      armed      <= 1'b0;
      PC         <= RESET_PC;
      Instr      <= '0;
      InstrCount <= '0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
      if (state == FETCH && IMValid) begin
        Instr <= IMRdata;
      end
      if (state == EXEC && !Stall) begin
        PC         <= next_pc;
        InstrCount <= InstrCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses and
// retired-instruction records; a negedge monitor pops and compares them.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
  } exec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, jump, zero, stall;
  logic [31:0] simm;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_valid;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4, instr_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_fetch[$];
  exec_t       exp_exec[$];

  // Bench-side model of architectural state.
  logic [31:0] pc_m;
  logic [31:0] cnt_m;
  logic [31:0] cur_instr;

  fetch_unit #(.WL(32), .RESET_PC(32'h0)) dut (
    .CLK       (clk),
    .RST       (rst),
    .Branch    (branch),
    .Jump      (jump),
    .Zero      (zero),
    .SImm      (simm),
    .Stall     (stall),
    .IMReq     (im_req),
    .IMAddr    (im_addr),
    .IMRdata   (im_rdata),
    .IMValid   (im_valid),
    .Instr     (instr),
    .Opcode    (opcode),
    .funct     (funct),
    .InstrValid(instr_valid),
    .PC        (pc),
    .PCPlus4   (pc_plus4),
    .InstrCount(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; direct checks happen in the same slot.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " PC"},         pc,                 32'h0);
    check({tag, " IMAddr"},     im_addr,            32'h0);
    check({tag, " Instr"},      instr,              32'h0);
    check({tag, " InstrValid"}, {31'b0, instr_valid}, 32'h0);
    check({tag, " IMReq"},      {31'b0, im_req},    32'h0);
    check({tag, " InstrCount"}, instr_count,        32'h0);
  endtask

  // Serve one fetch: wait (bounded) for IMReq, hold IMValid low for 'delay' cycles,
  // then return 'data'. Leaves the DUT in EXEC.
  task automatic do_fetch(input logic [31:0] data, input int delay);
    int waited = 0;
    while (im_req !== 1'b1 && waited < 8) begin
      step();
      waited++;
    end
    if (im_req !== 1'b1) begin
      check("fetch request timeout", {31'b0, im_req}, 32'h1);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      im_valid = 1'b0;
      step();
      check("wait IMReq held", {31'b0, im_req}, 32'h1);
      check("wait IMAddr stable", im_addr, pc_m);
      check("wait Instr unchanged", instr, cur_instr);
    end
    exp_fetch.push_back(pc_m);
    exp_exec.push_back('{pc: pc_m, instr: data, cnt: cnt_m});
    im_valid = 1'b1;
    im_rdata = data;
    cur_instr = data;
    step();
    im_valid = 1'b0;
    im_rdata = 32'hA5A5_5A5A;
  endtask

  // Hold EXEC for 'stalls' cycles with decoy control inputs, then exit with the
  // given controls; exp_next is the hand-computed next PC.
  task automatic do_exec(input int stalls, input logic j, input logic b, input logic z,
                         input logic [31:0] si, input logic [31:0] exp_next);
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      jump = 1'b1; branch = 1'b1; zero = 1'b1; simm = 32'h0000_0100;
      step();
      check("stall InstrValid", {31'b0, instr_valid}, 32'h1);
      check("stall Instr", instr, cur_instr);
      check("stall PC", pc, pc_m);
      check("stall InstrCount", instr_count, cnt_m);
    end
    stall = 1'b0;
    jump = j; branch = b; zero = z; simm = si;
    step();
    jump = 1'b0; branch = 1'b0; zero = 1'b0; simm = 32'h0;
    pc_m  = exp_next;
    cnt_m = cnt_m + 32'd1;
    check("exit PC", pc, pc_m);
    check("exit InstrCount", instr_count, cnt_m);
  endtask

  // Monitor: memory handshakes and EXEC entries are checked against the queues.
  initial begin
    logic prev_iv = 1'b0;
    exec_t e;
    forever begin
      @(negedge clk);
      if (!rst && im_req && im_valid) begin
        if (exp_fetch.size() == 0) begin
          check("unexpected fetch", 32'h1, 32'h0);
        end else begin
          check("fetch IMAddr", im_addr, exp_fetch.pop_front());
        end
      end
      if (instr_valid && !prev_iv) begin
        if (exp_exec.size() == 0) begin
          check("unexpected exec", 32'h1, 32'h0);
        end else begin
          e = exp_exec.pop_front();
          check("exec Instr", instr, e.instr);
          check("exec PC", pc, e.pc);
          check("exec PCPlus4", pc_plus4, e.pc + 32'd4);
          check("exec InstrCount", instr_count, e.cnt);
          check("exec Opcode", {26'b0, opcode}, {26'b0, e.instr[31:26]});
          check("exec funct", {26'b0, funct}, {26'b0, e.instr[5:0]});
        end
      end
      prev_iv = instr_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    branch = 1'b0; jump = 1'b0; zero = 1'b0; stall = 1'b0;
    simm = 32'h0; im_rdata = 32'h0; im_valid = 1'b0;
    pc_m = 32'h0; cnt_m = 32'h0; cur_instr = 32'h0;

    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    step();
    check("edge1 IMReq low", {31'b0, im_req}, 32'h0);
    step();
    check("edge2 IMReq high", {31'b0, im_req}, 32'h1);
    check("edge2 IMAddr", im_addr, 32'h0);

    // Sequential flow, branches taken/not taken, jumps.
    do_fetch(32'h0000_0020, 0);  do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004);
    do_fetch(32'h2008_0005, 0);  do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008);
    do_fetch(32'h1000_FFFF, 0);  do_exec(0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0008);
    do_fetch(32'h1000_FFFF, 0);  do_exec(0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_000C);
    do_fetch(32'h0810_0000, 0);  do_exec(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0000);
    // Slow memory, five stall cycles, jump with unknown Branch.
    do_fetch(32'h0800_0010, 3);  do_exec(5, 1'b1, 1'bx, 1'b1, 32'h0000_0005, 32'h0000_0040);
    // Backward branch to the top of the address space, then PC+4 wraps to zero.
    do_fetch(32'h1000_FFEE, 0);  do_exec(0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFEE, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0000, 0);  do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000);

    // Reset in the middle of a pending fetch; a late IMValid must be ignored.
    check("pre-abort IMReq", {31'b0, im_req}, 32'h1);
    step();
    check("pre-abort IMReq held", {31'b0, im_req}, 32'h1);
    rst = 1'b1;
    #1;
    check_reset_state("abort");
    im_valid = 1'b1;
    im_rdata = 32'hDEAD_BEEF;
    step();
    step();
    rst = 1'b0;
    step();
    check("abort edge1 IMReq low", {31'b0, im_req}, 32'h0);
    check("abort edge1 Instr", instr, 32'h0);
    check("abort edge1 InstrCount", instr_count, 32'h0);
    check("abort edge1 PC", pc, 32'h0);
    im_valid = 1'b0;
    step();
    check("abort edge2 IMReq high", {31'b0, im_req}, 32'h1);
    pc_m = 32'h0; cnt_m = 32'h0; cur_instr = 32'h0;

    do_fetch(32'h0000_0020, 0);  do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004);
    step();
    step();

    check("fetch queue drained", exp_fetch.size(), 32'h0);
    check("exec queue drained", exp_exec.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
